// File: rtl/alu_issue_queue.sv
// Command FIFO feeding a combinational ALU, with a registered result stage.
// Define ALU_ISSUE_STATS_EN to add the issued/stall counters.
module alu_issue_queue #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_sel_i,
  input  logic [DWIDTH-1:0]        cmd_op1_i,
  input  logic [DWIDTH-1:0]        cmd_op2_i,
  output logic [1:0]               alu_sel_o,
  output logic [DWIDTH-1:0]        alu_op1_o,
  output logic [DWIDTH-1:0]        alu_op2_o,
  input  logic [DWIDTH-1:0]        alu_res_i,
  input  logic                     alu_zero_i,
  input  logic                     alu_neg_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DWIDTH-1:0]        res_o,
  output logic                     zero_o,
  output logic                     neg_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              issued_cnt_o,
  output logic [15:0]              stall_cnt_o
`endif
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // a valid producer holds its payload stable until that edge.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic R_EMPTY = 1'b0;
  localparam logic R_FULL  = 1'b1;

  logic [1:0]        sel_mem [DEPTH];
  logic [DWIDTH-1:0] op1_mem [DEPTH];
  logic [DWIDTH-1:0] op2_mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              state_q, state_d;
  logic [DWIDTH-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  logic full, empty, push, issue;

  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    push     = cmd_valid_i && !full;
    issue    = !empty && (state_q == R_EMPTY || res_ready_i);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      res_d    = alu_res_i;
      zero_d   = alu_zero_i;
      neg_d    = alu_neg_i;
      state_d  = R_FULL;
    end else if (state_q == R_FULL && res_ready_i) begin
      // Drained with nothing left to issue; payload keeps its last value.
      state_d = R_EMPTY;
    end
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= R_EMPTY;
      res_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr_q] <= cmd_sel_i;
      op1_mem[wr_ptr_q] <= cmd_op1_i;
      op2_mem[wr_ptr_q] <= cmd_op2_i;
    end
  end

  assign cmd_ready_o = !full;
  assign alu_sel_o   = empty ? 2'b00 : sel_mem[rd_ptr_q];
  assign alu_op1_o   = empty ? '0 : op1_mem[rd_ptr_q];
  assign alu_op2_o   = empty ? '0 : op2_mem[rd_ptr_q];
  assign res_valid_o = (state_q == R_FULL);
  assign res_o       = res_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
  assign count_o     = count_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else if (state_q == R_FULL) begin
      if (res_ready_i) begin
        if (issued_q != 16'hFFFF) issued_q <= issued_q + 1'b1;
      end else begin
        if (stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign issued_cnt_o = issued_q;
  assign stall_cnt_o  = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_alu_issue_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic          cmd_valid_i, cmd_ready_o;
  logic [1:0]    cmd_sel_i;
  logic [DW-1:0] cmd_op1_i, cmd_op2_i;
  logic [1:0]    alu_sel_o;
  logic [DW-1:0] alu_op1_o, alu_op2_o;
  logic [DW-1:0] alu_res_i;
  logic          alu_zero_i, alu_neg_i;
  logic          res_valid_o, res_ready_i;
  logic [DW-1:0] res_o;
  logic          zero_o, neg_o;
  logic [CW-1:0] count_o;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]   issued_cnt_o, stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: expected {neg,zero,res} of queued commands, plus the
  // result slot as the consumer should see it.
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] slot;
  bit            slot_v;
  int            issued_m, stall_m;

  alu_issue_queue #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_sel_i(cmd_sel_i), .cmd_op1_i(cmd_op1_i), .cmd_op2_i(cmd_op2_i),
    .alu_sel_o(alu_sel_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
    .alu_res_i(alu_res_i), .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .zero_o(zero_o), .neg_o(neg_o), .count_o(count_o)
`ifdef ALU_ISSUE_STATS_EN
    , .issued_cnt_o(issued_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // The combinational ALU the queue drives.
  always_comb begin
    case (alu_sel_o)
      2'b00:   alu_res_i = alu_op1_o + alu_op2_o;
      2'b01:   alu_res_i = alu_op1_o - alu_op2_o;
      2'b10:   alu_res_i = alu_op1_o & alu_op2_o;
      default: alu_res_i = alu_op1_o | alu_op2_o;
    endcase
    alu_zero_i = (alu_res_i == '0);
    alu_neg_i  = alu_res_i[DW-1];
  end

  function automatic logic [DW+1:0] exp_of(input logic [1:0] sel, input int a, input int b);
    int r;
    case (sel)
      2'b00:   r = (a + b) % 256;
      2'b01:   r = (a - b + 256) % 256;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {(r >= 128) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, DW'(r)};
  endfunction

  // Driver tasks
  task automatic model_edge();
    int  sz;
    bit  push_ok;
    sz = exp_q.size();
    push_ok = cmd_valid_i && (sz != DEPTH);
    if (slot_v && res_ready_i)  issued_m++;
    if (slot_v && !res_ready_i) stall_m++;
    if (sz != 0 && (!slot_v || res_ready_i)) begin
      slot   = exp_q.pop_front();
      slot_v = 1'b1;
    end else if (slot_v && res_ready_i) begin
      slot_v = 1'b0;
    end
    if (push_ok) exp_q.push_back(exp_of(cmd_sel_i, int'(cmd_op1_i), int'(cmd_op2_i)));
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [1:0] s, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
    cmd_valid_i = v;
    cmd_sel_i   = s;
    cmd_op1_i   = a;
    cmd_op2_i   = b;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_cmd(1'b0, 2'b00, '0, '0);
    res_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    slot = '0;
    slot_v = 1'b0;
    issued_m = 0;
    stall_m = 0;
    @(posedge clk);
    #1;
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset_dut();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid_o); end
    checks++; if ({neg_o, zero_o, res_o} !== '0) begin errors++; $display("FAIL reset_res: got %h want 0", {neg_o, zero_o, res_o}); end
    checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
    checks++; if ({alu_sel_o, alu_op1_o, alu_op2_o} !== '0) begin errors++; $display("FAIL reset_alu_drive: got %h want 0", {alu_sel_o, alu_op1_o, alu_op2_o}); end
  endtask

  task automatic test_single_add();
    reset_dut();
    res_ready_i = 1'b1;
    drive_cmd(1'b1, 2'b00, 8'h05, 8'h03);
    tick();
    drive_cmd(1'b0, 2'b00, '0, '0);
    checks++; if ({res_valid_o, count_o} !== {1'b0, CW'(1)}) begin errors++; $display("FAIL add_queued: got valid=%b count=%0d want 0/1", res_valid_o, count_o); end
    checks++; if ({alu_sel_o, alu_op1_o, alu_op2_o} !== {2'b00, 8'h05, 8'h03}) begin errors++; $display("FAIL add_head_drive: got %h want 00_05_03", {alu_sel_o, alu_op1_o, alu_op2_o}); end
    tick();
    checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {1'b1, 1'b0, 1'b0, 8'h08}) begin errors++; $display("FAIL add_result: got v=%b n=%b z=%b r=%h want 1/0/0/08", res_valid_o, neg_o, zero_o, res_o); end
    checks++; if (count_o !== '0) begin errors++; $display("FAIL add_count: got %0d want 0", count_o); end
    tick();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL add_consumed: got %b want 0", res_valid_o); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    res_ready_i = 1'b1;
    drive_cmd(1'b1, 2'b01, 8'h03, 8'h05);
    tick();
    drive_cmd(1'b1, 2'b01, 8'h07, 8'h07);
    tick();
    drive_cmd(1'b0, 2'b00, '0, '0);
    checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {1'b1, 1'b1, 1'b0, 8'hFE}) begin errors++; $display("FAIL b2b_first: got v=%b n=%b z=%b r=%h want 1/1/0/fe", res_valid_o, neg_o, zero_o, res_o); end
    tick();
    checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL b2b_second: got v=%b n=%b z=%b r=%h want 1/0/1/00", res_valid_o, neg_o, zero_o, res_o); end
  endtask

  task automatic test_stall();
    logic [1:0]    sels [5] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
    logic [DW-1:0] a    [5] = '{8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h10};
    logic [DW-1:0] b    [5] = '{8'h3C, 8'h10, 8'h01, 8'h01, 8'h10};
    logic [DW+1:0] want [5] = '{{2'b00, 8'h30}, {2'b00, 8'h1F}, {2'b01, 8'h00}, {2'b10, 8'hFF}, {2'b00, 8'h20}};
    reset_dut();
    res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, sels[i], a[i], b[i]);
      tick();
    end
    checks++; if ({res_valid_o, res_o} !== {1'b1, 8'h30}) begin errors++; $display("FAIL stall_head_result: got v=%b r=%h want 1/30", res_valid_o, res_o); end
    checks++; if ({cmd_ready_o, count_o} !== {1'b0, CW'(4)}) begin errors++; $display("FAIL stall_full: got ready=%b count=%0d want 0/4", cmd_ready_o, count_o); end
    drive_cmd(1'b1, 2'b00, 8'hAA, 8'h11);
    tick();
    drive_cmd(1'b0, 2'b00, '0, '0);
    checks++; if (count_o !== CW'(4)) begin errors++; $display("FAIL stall_sixth_rejected: got count=%0d want 4", count_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {1'b1, 2'b00, 8'h30}) begin errors++; $display("FAIL stall_hold: got v=%b n=%b z=%b r=%h want 1/0/0/30", res_valid_o, neg_o, zero_o, res_o); end
    end
    res_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {1'b1, want[i]}) begin errors++; $display("FAIL drain_result%0d: got v=%b nzr=%h want 1/%h", i, res_valid_o, {neg_o, zero_o, res_o}, want[i]); end
      checks++; if (count_o !== CW'(4 - i)) begin errors++; $display("FAIL drain_count%0d: got %0d want %0d", i, count_o, 4 - i); end
      tick();
    end
    checks++; if ({res_valid_o, count_o} !== {1'b0, CW'(0)}) begin errors++; $display("FAIL drain_done: got v=%b count=%0d want 0/0", res_valid_o, count_o); end
`ifdef ALU_ISSUE_STATS_EN
    checks++; if (issued_cnt_o !== 16'd5) begin errors++; $display("FAIL stats_issued: got %0d want 5", issued_cnt_o); end
    checks++; if (stall_cnt_o !== 16'(stall_m)) begin errors++; $display("FAIL stats_stall: got %0d want %0d", stall_cnt_o, stall_m); end
`endif
  endtask

  task automatic test_reset_midstream();
    reset_dut();
    res_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      tick();
    end
    drive_cmd(1'b0, 2'b00, '0, '0);
    rst = 1'b1;
    #1;
    checks++; if ({res_valid_o, res_o, count_o, cmd_ready_o} !== {1'b0, 8'h00, CW'(0), 1'b1}) begin errors++; $display("FAIL midreset: got v=%b r=%h count=%0d ready=%b want 0/00/0/1", res_valid_o, res_o, count_o, cmd_ready_o); end
    reset_dut();
    res_ready_i = 1'b1;
    drive_cmd(1'b1, 2'b11, 8'h40, 8'h02);
    tick();
    drive_cmd(1'b0, 2'b00, '0, '0);
    tick();
    checks++; if ({res_valid_o, res_o, count_o} !== {1'b1, 8'h42, CW'(0)}) begin errors++; $display("FAIL post_reset_cmd: got v=%b r=%h count=%0d want 1/42/0", res_valid_o, res_o, count_o); end
  endtask

  task automatic test_stream();
    reset_dut();
    res_ready_i = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i < 20) drive_cmd(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      else        drive_cmd(1'b0, 2'b00, '0, '0);
      tick();
      if (i >= 1 && i < 20) begin
        checks++; if (count_o !== CW'(1)) begin errors++; $display("FAIL stream_count%0d: got %0d want 1", i, count_o); end
      end
      checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {slot_v, slot}) begin errors++; $display("FAIL stream_result%0d: got v=%b nzr=%h want %b/%h", i, res_valid_o, {neg_o, zero_o, res_o}, slot_v, slot); end
    end
    checks++; if ({res_valid_o, count_o} !== {1'b0, CW'(0)} || exp_q.size() != 0) begin errors++; $display("FAIL stream_drained: got v=%b count=%0d left=%0d want 0/0/0", res_valid_o, count_o, exp_q.size()); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 60) drive_cmd(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      else                            drive_cmd(1'b0, 2'b00, '0, '0);
      res_ready_i = ($urandom_range(0, 99) < 55);
      checks++; if ({res_valid_o, neg_o, zero_o, res_o} !== {slot_v, slot}) begin errors++; $display("FAIL rand_result%0d: got v=%b nzr=%h want %b/%h", i, res_valid_o, {neg_o, zero_o, res_o}, slot_v, slot); end
      checks++; if (count_o !== CW'(exp_q.size())) begin errors++; $display("FAIL rand_count%0d: got %0d want %0d", i, count_o, exp_q.size()); end
      checks++; if (cmd_ready_o !== (exp_q.size() != DEPTH)) begin errors++; $display("FAIL rand_ready%0d: got %b want %b", i, cmd_ready_o, exp_q.size() != DEPTH); end
      tick();
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++; if ({issued_cnt_o, stall_cnt_o} !== {16'(issued_m), 16'(stall_m)}) begin errors++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", issued_cnt_o, stall_cnt_o, issued_m, stall_m); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    res_ready_i = 1'b0;
    drive_cmd(1'b0, 2'b00, '0, '0);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Buffers ALU operation requests and issues them to the combinational alu.
Commands arrive on a valid/ready interface and are held in a small FIFO.
The FIFO head drives the alu's sel_i/op1_i/op2_i, and the alu's res_o/zero_o/neg_o are captured into a registered result stage with its own valid/ready interface.
The block sits between the operand/command source and writeback: it feeds the alu and consumes what the alu produces.

Parameters:
DWIDTH, 8, operand/result width; matches alu DWIDTH.
DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  queue can accept a command
cmd_sel_i  input  2  alu op: 00 add, 01 sub, 10 and, 11 or
cmd_op1_i  input  DWIDTH  operand 1
cmd_op2_i  input  DWIDTH  operand 2
alu_sel_o  output  2  to alu sel_i
alu_op1_o  output  DWIDTH  to alu op1_i
alu_op2_o  output  DWIDTH  to alu op2_i
alu_res_i  input  DWIDTH  from alu res_o
alu_zero_i  input  1  from alu zero_o
alu_neg_i  input  1  from alu neg_o
res_valid_o  output  1  registered result valid
res_ready_i  input  1  consumer accepts result
res_o  output  DWIDTH  registered result
zero_o  output  1  registered zero flag
neg_o  output  1  registered negative flag
count_o  output  $clog2(DEPTH)+1  FIFO occupancy (excludes result register)

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers = 0, count_o = 0.
  - res_valid_o = 0; res_o, zero_o, neg_o = 0.
  - cmd_ready_o = 1 (combinational !full).
- Push: on cmd_valid_i && cmd_ready_o, write {sel, op1, op2} at the write pointer; the pointer wraps modulo DEPTH.
- cmd_ready_o = (count_o != DEPTH). It does not depend on a same-cycle pop, so there is no combinational path from res_ready_i to cmd_ready_o.
- ALU drive:
  - Non-empty: alu_* outputs = FIFO head entry, combinationally from storage.
  - Empty: alu_* outputs = 0.
- Result stage is a 2-state FSM:
  - R_EMPTY: res_valid_o = 0.
  - R_FULL: res_valid_o = 1.
- Issue condition: issue = !empty && (state == R_EMPTY || res_ready_i).
  - On issue: capture alu_res_i/alu_zero_i/alu_neg_i into res_o/zero_o/neg_o, pop the head, state -> R_FULL.
  - R_FULL && res_ready_i && empty: state -> R_EMPTY. res_o/zero_o/neg_o keep their last value.
  - R_FULL && !res_ready_i: res_o/zero_o/neg_o/res_valid_o held stable.
- Latency: a command pushed at edge N into an empty queue with the result stage empty gives res_valid_o = 1 after edge N+1. Pushed data is never bypassed.
- Throughput: one result per cycle when res_ready_i is held at 1 and the queue is non-empty.
- Simultaneous push and pop: count_o unchanged, and both pointers advance.
- Ordering: results appear strictly in command order.
- Arithmetic is modulo 2^DWIDTH; flags are taken from the alu, never recomputed.
- Reset mid-operation: queued commands and any pending result are discarded, and all outputs return to their reset values.
- Consumer protocol: the consumer must not see res_valid_o drop without a handshake.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined:
  - Adds output issued_cnt_o [15:0]: increments on each res_valid_o && res_ready_i, saturates at 0xFFFF.
  - Adds output stall_cnt_o [15:0]: increments each cycle with res_valid_o && !res_ready_i, saturates at 0xFFFF.
  - Both counters reset to 0 on rst.
- When undefined: neither port nor the counter logic exists, and all other behaviour is identical.

Test Plan:
1. Assert rst mid-stream with 3 queued commands -> immediately res_valid_o=0, res_o=0x00, count_o=0, cmd_ready_o=1; after release the queue accepts new commands normally.
2. DWIDTH=8, res_ready_i=1, push sel=00 op1=0x05 op2=0x03 -> one edge later res_valid_o=1, res_o=0x08, zero_o=0, neg_o=0.
3. Push sub 0x03-0x05 then sub 0x07-0x07 back-to-back -> consecutive cycles give res_o=0xFE (neg_o=1, zero_o=0), then res_o=0x00 (zero_o=1, neg_o=0).
4. res_ready_i=0, DEPTH=4, push 5 commands (and 0xF0&0x3C, or 0x0F|0x10, add 0xFF+0x01, sub 0x00-0x01, add 0x10+0x10):
   - After pushes: result register holds 0x30; count_o=4; cmd_ready_o=0; the 6th cmd_valid_i is not accepted.
   - res_o stays 0x30 while stalled.
   - Raise res_ready_i -> results 0x30, 0x1F, 0x00 (zero_o=1), 0xFF (neg_o=1), 0x20 on consecutive cycles; count_o falls to 0.
5. Continuous push and pop with res_ready_i=1 for 20 cycles -> count_o stays constant, one in-order result per cycle, and both pointers wrap past DEPTH without loss.
6. With ALU_ISSUE_STATS_EN defined, run scenario 4 -> issued_cnt_o=5; stall_cnt_o equals the number of stalled cycles counted by the bench.
